muxkey_lut_reg: RTL and testbench

//   Runtime-programmable key->data lookup table with a registered, handshaked lookup port.
//   It is the sequential successor to the combinational key mux.

---
 rtl/muxkey_lut_reg.sv | 150 +++++++++++++++
 tb/tb_muxkey_lut_reg.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muxkey_lut_reg.sv
// muxkey_lut_reg: runtime-programmable key->data lookup table with a registered,
// valid/ready handshaked lookup port and a saturating miss counter.
//
// Ports:
//   clk, rst                       clock; synchronous active-high reset
//   wr_en/wr_idx/wr_vld            table write strobe, target entry, install(1)/invalidate(0)
//   wr_key/wr_data                 key and data installed when wr_vld=1
//   def_data                       data returned on a miss (HAS_DEFAULT=1), sampled at accept
//   req_valid/req_ready/req_key    lookup request channel (req_ready is combinational)
//   rsp_valid/rsp_ready            response channel, held stable under backpressure
//   rsp_data/rsp_hit/rsp_idx       registered lookup result
//   miss_cnt                       saturating count of accepted misses
module muxkey_lut_reg #(
   parameter int unsigned NR_KEY      = 4,
   parameter int unsigned KEY_LEN     = 2,
   parameter int unsigned DATA_LEN    = 8,
   parameter int unsigned HAS_DEFAULT = 1,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [$clog2(NR_KEY)-1:0] wr_idx,
   input  logic                      wr_vld,
   input  logic [KEY_LEN-1:0]        wr_key,
   input  logic [DATA_LEN-1:0]       wr_data,
   input  logic [DATA_LEN-1:0]       def_data,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [KEY_LEN-1:0]        req_key,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_LEN-1:0]       rsp_data,
   output logic                      rsp_hit,
   output logic [$clog2(NR_KEY)-1:0] rsp_idx,
   output logic [CNT_W-1:0]          miss_cnt
);

   localparam int unsigned IDX_W = $clog2(NR_KEY);

   logic                valid_q [NR_KEY];
   logic                valid_d [NR_KEY];
   logic [KEY_LEN-1:0]  key_q   [NR_KEY];
   logic [KEY_LEN-1:0]  key_d   [NR_KEY];
   logic [DATA_LEN-1:0] data_q  [NR_KEY];
   logic [DATA_LEN-1:0] data_d  [NR_KEY];

   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_LEN-1:0] rsp_data_q,  rsp_data_d;
   logic                rsp_hit_q,   rsp_hit_d;
   logic [IDX_W-1:0]    rsp_idx_q,   rsp_idx_d;
   logic [CNT_W-1:0]    miss_cnt_q,  miss_cnt_d;

   logic                accept_c;
   logic                hit_c;
   logic [IDX_W-1:0]    hit_idx_c;
   logic [DATA_LEN-1:0] hit_data_c;

   // 1-deep pipeline: a new request may enter whenever the output slot drains this cycle
   assign req_ready = !rsp_valid_q || rsp_ready;
   assign accept_c  = req_valid && req_ready;

   // Table write; an out-of-range wr_idx matches no entry and is dropped
   always_comb begin
      for (int unsigned i = 0; i < NR_KEY; i++) begin
         valid_d[i] = valid_q[i];
         key_d[i]   = key_q[i];
         data_d[i]  = data_q[i];
         if (wr_en && (wr_idx == IDX_W'(i))) begin
            valid_d[i] = wr_vld;
            if (wr_vld) begin
               key_d[i]  = wr_key;
               data_d[i] = wr_data;
            end
         end
      end
   end

   // Priority match on the pre-write table: first (lowest) matching entry wins
   always_comb begin
      hit_c      = 1'b0;
      hit_idx_c  = '0;
      hit_data_c = '0;
      for (int unsigned i = 0; i < NR_KEY; i++) begin
         if (!hit_c && valid_q[i] && (key_q[i] == req_key)) begin
            hit_c      = 1'b1;
            hit_idx_c  = IDX_W'(i);
            hit_data_c = data_q[i];
         end
      end
   end

   // Response slot and miss counter; a held response is only replaced by a new accept
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_hit_d   = rsp_hit_q;
      rsp_idx_d   = rsp_idx_q;
      miss_cnt_d  = miss_cnt_q;
      if (accept_c) begin
         rsp_valid_d = 1'b1;
         rsp_hit_d   = hit_c;
         rsp_idx_d   = hit_idx_c;
         if (hit_c) begin
            rsp_data_d = hit_data_c;
         end else begin
            rsp_data_d = (HAS_DEFAULT != 0) ? def_data : '0;
            if (miss_cnt_q != '1) begin
               miss_cnt_d = miss_cnt_q + CNT_W'(1);
            end
         end
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NR_KEY; i++) begin
            valid_q[i] <= 1'b0;
            key_q[i]   <= '0;
            data_q[i]  <= '0;
         end
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_hit_q   <= 1'b0;
         rsp_idx_q   <= '0;
         miss_cnt_q  <= '0;
      end else begin
         for (int unsigned i = 0; i < NR_KEY; i++) begin
            valid_q[i] <= valid_d[i];
            key_q[i]   <= key_d[i];
            data_q[i]  <= data_d[i];
         end
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_hit_q   <= rsp_hit_d;
         rsp_idx_q   <= rsp_idx_d;
         miss_cnt_q  <= miss_cnt_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_hit   = rsp_hit_q;
   assign rsp_idx   = rsp_idx_q;
   assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_muxkey_lut_reg.sv
// tb_muxkey_lut_reg: directed scenarios plus a randomized run against a table model.
// dut_a uses default parameters; dut_b uses HAS_DEFAULT=0, CNT_W=2 for saturation.
module tb_muxkey_lut_reg;

   localparam int unsigned NK  = 4;
   localparam int unsigned KL  = 2;
   localparam int unsigned DL  = 8;
   localparam int unsigned IW  = 2;
   localparam int unsigned CW  = 16;
   localparam int unsigned CWB = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // dut_a signals
   logic          rst, wr_en, wr_vld, req_valid, rsp_ready;
   logic [IW-1:0] wr_idx;
   logic [KL-1:0] wr_key, req_key;
   logic [DL-1:0] wr_data, def_data;
   logic          req_ready, rsp_valid, rsp_hit;
   logic [DL-1:0] rsp_data;
   logic [IW-1:0] rsp_idx;
   logic [CW-1:0] miss_cnt;

   // dut_b signals
   logic           b_rst, b_wr_en, b_wr_vld, b_req_valid, b_rsp_ready;
   logic [IW-1:0]  b_wr_idx;
   logic [KL-1:0]  b_wr_key, b_req_key;
   logic [DL-1:0]  b_wr_data, b_def_data;
   logic           b_req_ready, b_rsp_valid, b_rsp_hit;
   logic [DL-1:0]  b_rsp_data;
   logic [IW-1:0]  b_rsp_idx;
   logic [CWB-1:0] b_miss_cnt;

   int errors = 0;
   int checks = 0;

   muxkey_lut_reg #(.NR_KEY(NK), .KEY_LEN(KL), .DATA_LEN(DL), .HAS_DEFAULT(1), .CNT_W(CW)) dut_a (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_vld(wr_vld),
      .wr_key(wr_key), .wr_data(wr_data), .def_data(def_data),
      .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_hit(rsp_hit), .rsp_idx(rsp_idx), .miss_cnt(miss_cnt));

   muxkey_lut_reg #(.NR_KEY(NK), .KEY_LEN(KL), .DATA_LEN(DL), .HAS_DEFAULT(0), .CNT_W(CWB)) dut_b (
      .clk(clk), .rst(b_rst), .wr_en(b_wr_en), .wr_idx(b_wr_idx), .wr_vld(b_wr_vld),
      .wr_key(b_wr_key), .wr_data(b_wr_data), .def_data(b_def_data),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_key(b_req_key),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
      .rsp_hit(b_rsp_hit), .rsp_idx(b_rsp_idx), .miss_cnt(b_miss_cnt));

   // Reference model of dut_a: plain table arrays plus miss count
   typedef struct packed {
      logic          hit;
      logic [IW-1:0] idx;
      logic [DL-1:0] data;
   } rsp_t;

   logic          m_valid [NK];
   logic [KL-1:0] m_key   [NK];
   logic [DL-1:0] m_data  [NK];
   int            m_miss;

   function automatic rsp_t model_lookup(input logic [KL-1:0] k, input logic [DL-1:0] dflt);
      rsp_t r;
      r.hit  = 1'b0;
      r.idx  = '0;
      r.data = dflt;
      // scan downward so the lowest matching index is the last one kept
      for (int n = NK - 1; n >= 0; n--) begin
         if (m_valid[n] && m_key[n] == k) begin
            r.hit  = 1'b1;
            r.idx  = IW'(n);
            r.data = m_data[n];
         end
      end
      return r;
   endfunction

   task automatic model_write(input int idx, input logic vld, input logic [KL-1:0] k,
                              input logic [DL-1:0] d);
      if (idx < NK) begin
         m_valid[idx] = vld;
         if (vld) begin
            m_key[idx]  = k;
            m_data[idx] = d;
         end
      end
   endtask

   task automatic model_count(input rsp_t r);
      if (!r.hit && m_miss < (1 << CW) - 1) m_miss++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single write cycle on dut_a, mirrored into the model after the edge
   task automatic do_write(input int idx, input logic vld, input logic [KL-1:0] k,
                           input logic [DL-1:0] d);
      wr_en = 1'b1; wr_idx = IW'(idx); wr_vld = vld; wr_key = k; wr_data = d;
      tick();
      wr_en = 1'b0;
      model_write(idx, vld, k, d);
   endtask

   // Single lookup with rsp_ready=1; checks response and drain, returns observed response
   task automatic do_lookup(input logic [KL-1:0] k, input string nm, output rsp_t got);
      rsp_t e;
      rsp_ready = 1'b1; req_valid = 1'b1; req_key = k;
      e = model_lookup(k, def_data);
      tick();
      req_valid = 1'b0;
      model_count(e);
      got = {rsp_hit, rsp_idx, rsp_data};
      checks++;
      if (rsp_valid !== 1'b1) begin
         errors++; $display("FAIL %s_valid: got %0b want 1", nm, rsp_valid);
      end
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL %s_rsp: got hit=%0b idx=%0d data=%h want hit=%0b idx=%0d data=%h",
                  nm, got.hit, got.idx, got.data, e.hit, e.idx, e.data);
      end
      checks++;
      if (miss_cnt !== CW'(m_miss)) begin
         errors++; $display("FAIL %s_miss_cnt: got %0d want %0d", nm, miss_cnt, m_miss);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++; $display("FAIL %s_drain: rsp_valid got %0b want 0", nm, rsp_valid);
      end
   endtask

   task automatic test_reset();
      rsp_t got;
      rst = 1'b1; b_rst = 1'b1;
      tick();
      tick();
      rst = 1'b0; b_rst = 1'b0;
      for (int n = 0; n < NK; n++) begin
         m_valid[n] = 1'b0; m_key[n] = '0; m_data[n] = '0;
      end
      m_miss = 0;
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid);
      end
      checks++;
      if (miss_cnt !== '0) begin
         errors++; $display("FAIL reset_miss_cnt: got %0d want 0", miss_cnt);
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL reset_req_ready: got %0b want 1", req_ready);
      end
      def_data = 8'h5C;
      do_lookup(2'd0, "reset_lookup0", got);
      checks++;
      if (got.hit !== 1'b0 || got.data !== 8'h5C) begin
         errors++; $display("FAIL reset_key0_miss: got hit=%0b data=%h want hit=0 data=5c", got.hit, got.data);
      end
   endtask

   task automatic test_write_hit();
      rsp_t got;
      do_write(1, 1'b1, 2'd2, 8'hA5);
      do_lookup(2'd2, "write_hit", got);
      checks++;
      if (got.hit !== 1'b1 || got.idx !== 2'd1 || got.data !== 8'hA5) begin
         errors++; $display("FAIL write_hit_const: got hit=%0b idx=%0d data=%h want 1/1/a5", got.hit, got.idx, got.data);
      end
   endtask

   task automatic test_priority();
      rsp_t got;
      do_write(0, 1'b1, 2'd3, 8'h11);
      do_write(2, 1'b1, 2'd3, 8'h22);
      do_lookup(2'd3, "priority", got);
      checks++;
      if (got.idx !== 2'd0 || got.data !== 8'h11) begin
         errors++; $display("FAIL priority_low_idx: got idx=%0d data=%h want 0/11", got.idx, got.data);
      end
   endtask

   task automatic test_read_old();
      rsp_t e, got;
      wr_en = 1'b1; wr_idx = 2'd1; wr_vld = 1'b1; wr_key = 2'd1; wr_data = 8'h77;
      rsp_ready = 1'b1; req_valid = 1'b1; req_key = 2'd1;
      e = model_lookup(2'd1, def_data);
      tick();
      wr_en = 1'b0; req_valid = 1'b0;
      model_write(1, 1'b1, 2'd1, 8'h77);
      model_count(e);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_hit !== 1'b0 || rsp_data !== def_data) begin
         errors++; $display("FAIL read_old_miss: got v=%0b hit=%0b data=%h want 1/0/%h", rsp_valid, rsp_hit, rsp_data, def_data);
      end
      tick();
      do_lookup(2'd1, "read_old_again", got);
      checks++;
      if (got.hit !== 1'b1 || got.data !== 8'h77) begin
         errors++; $display("FAIL read_old_hit: got hit=%0b data=%h want 1/77", got.hit, got.data);
      end
   endtask

   task automatic test_backpressure();
      rsp_t e0, e1, e2, got;
      rsp_ready = 1'b0; req_valid = 1'b1; req_key = 2'd3;
      e0 = model_lookup(2'd3, def_data);
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL bp_ready_idle: got %0b want 1", req_ready);
      end
      tick();
      model_count(e0);
      for (int h = 0; h < 3; h++) begin
         // invalidate the entry that produced the held response; it must not change
         if (h == 0) begin
            wr_en = 1'b1; wr_idx = 2'd0; wr_vld = 1'b0; wr_key = 2'd0; wr_data = 8'h00;
         end
         #1;
         checks++;
         if (req_ready !== 1'b0) begin
            errors++; $display("FAIL bp_ready_hold%0d: got %0b want 0", h, req_ready);
         end
         got = {rsp_hit, rsp_idx, rsp_data};
         checks++;
         if (rsp_valid !== 1'b1 || got !== e0) begin
            errors++; $display("FAIL bp_hold%0d: got v=%0b data=%h idx=%0d want 1/%h/%0d", h, rsp_valid, got.data, got.idx, e0.data, e0.idx);
         end
         tick();
         if (h == 0) begin
            wr_en = 1'b0;
            model_write(0, 1'b0, 2'd0, 8'h00);
         end
      end
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL bp_ready_release: got %0b want 1", req_ready);
      end
      e1 = model_lookup(2'd3, def_data);
      tick();
      model_count(e1);
      req_key = 2'd1;
      got = {rsp_hit, rsp_idx, rsp_data};
      checks++;
      if (rsp_valid !== 1'b1 || got !== e1 || got.idx !== 2'd2) begin
         errors++; $display("FAIL bp_second: got v=%0b idx=%0d data=%h want 1/%0d/%h", rsp_valid, got.idx, got.data, e1.idx, e1.data);
      end
      e2 = model_lookup(2'd1, def_data);
      tick();
      model_count(e2);
      req_valid = 1'b0;
      got = {rsp_hit, rsp_idx, rsp_data};
      checks++;
      if (rsp_valid !== 1'b1 || got !== e2) begin
         errors++; $display("FAIL bp_third: got v=%0b idx=%0d data=%h want 1/%0d/%h", rsp_valid, got.idx, got.data, e2.idx, e2.data);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++; $display("FAIL bp_no_dup: rsp_valid got %0b want 0", rsp_valid);
      end
   endtask

   task automatic test_random();
      rsp_t pend, e, got;
      bit   have, acc;
      have = 1'b0;
      pend = '0;
      for (int c = 0; c < 400; c++) begin
         wr_en     = ($urandom_range(0, 3) == 0);
         wr_idx    = IW'($urandom);
         wr_vld    = ($urandom_range(0, 3) != 0);
         wr_key    = KL'($urandom);
         wr_data   = DL'($urandom);
         req_valid = ($urandom_range(0, 2) != 0);
         req_key   = KL'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         def_data  = DL'($urandom);
         #1;
         checks++;
         if (rsp_valid !== have) begin
            errors++; $display("FAIL rand_valid c=%0d: got %0b want %0b", c, rsp_valid, have);
         end
         if (have) begin
            got = {rsp_hit, rsp_idx, rsp_data};
            checks++;
            if (got !== pend) begin
               errors++;
               $display("FAIL rand_rsp c=%0d: got hit=%0b idx=%0d data=%h want hit=%0b idx=%0d data=%h",
                        c, got.hit, got.idx, got.data, pend.hit, pend.idx, pend.data);
            end
         end
         checks++;
         if (req_ready !== (!have || rsp_ready)) begin
            errors++; $display("FAIL rand_ready c=%0d: got %0b want %0b", c, req_ready, !have || rsp_ready);
         end
         acc = req_valid && (!have || rsp_ready);
         e = model_lookup(req_key, def_data);
         tick();
         if (have && rsp_ready) have = 1'b0;
         if (acc) begin
            have = 1'b1;
            pend = e;
            model_count(e);
         end
         if (wr_en) model_write(int'(wr_idx), wr_vld, wr_key, wr_data);
         checks++;
         if (miss_cnt !== CW'(m_miss)) begin
            errors++; $display("FAIL rand_miss_cnt c=%0d: got %0d want %0d", c, miss_cnt, m_miss);
         end
      end
      wr_en = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
      tick();
   endtask

   task automatic test_saturate();
      int want;
      b_rsp_ready = 1'b1; b_req_valid = 1'b1; b_def_data = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         b_req_key = KL'($urandom);
         tick();
         want = (i + 1 > 3) ? 3 : i + 1;
         checks++;
         if (b_rsp_valid !== 1'b1 || b_rsp_hit !== 1'b0 || b_rsp_data !== 8'h00 || b_rsp_idx !== 2'd0) begin
            errors++; $display("FAIL sat_rsp%0d: got v=%0b hit=%0b idx=%0d data=%h want 1/0/0/00", i, b_rsp_valid, b_rsp_hit, b_rsp_idx, b_rsp_data);
         end
         checks++;
         if (b_miss_cnt !== CWB'(want)) begin
            errors++; $display("FAIL sat_cnt%0d: got %0d want %0d", i, b_miss_cnt, want);
         end
      end
      // reset in the middle of a burst wins over the concurrent request
      b_rst = 1'b1;
      tick();
      b_rst = 1'b0;
      checks++;
      if (b_rsp_valid !== 1'b0 || b_miss_cnt !== '0) begin
         errors++; $display("FAIL sat_reset: got v=%0b cnt=%0d want 0/0", b_rsp_valid, b_miss_cnt);
      end
      b_req_valid = 1'b0;
      tick();
   endtask

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_vld = 1'b0; wr_key = '0; wr_data = '0;
      def_data = '0; req_valid = 1'b0; req_key = '0; rsp_ready = 1'b1;
      b_rst = 1'b1; b_wr_en = 1'b0; b_wr_idx = '0; b_wr_vld = 1'b0; b_wr_key = '0; b_wr_data = '0;
      b_def_data = '0; b_req_valid = 1'b0; b_req_key = '0; b_rsp_ready = 1'b1;
      test_reset();
      test_write_hit();
      test_priority();
      test_read_old();
      test_backpressure();
      test_random();
      test_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
